// File: rtl/id_pkg.sv
// Shared decode constants and ID/EX payload type for the decode stage.
package id_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // rt field selects the REGIMM branch flavour
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef enum logic [1:0] {NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3} npc_op_e;
  typedef enum logic [1:0] {EXT_SIGN = 2'd0, EXT_ZERO = 2'd1, EXT_LUI = 2'd2} ext_e;
  typedef enum logic [2:0] {
    CMP_NONE, CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ
  } cmp_e;

  // ID/EX payload; the valid bit travels separately in vld_pipe
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] link;
  } ex_data_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm16, input ext_e mode);
    case (mode)
      EXT_ZERO: ext_imm = {16'h0000, imm16};
      EXT_LUI:  ext_imm = {imm16, 16'h0000};
      default:  ext_imm = {{16{imm16[15]}}, imm16};
    endcase
  endfunction

endpackage

// File: rtl/id_stage_param_if.sv
// Decode-stage bus: IF/ID inputs, WB write port, hazard controls, redirect and ID/EX outputs.
interface id_stage_param_if #(parameter int AW = 5);
  logic [31:0]   instr_id;
  logic [31:0]   pc_id;
  logic          valid_id;
  logic [31:0]   fwd_rd1;
  logic [31:0]   fwd_rd2;
  logic          rf_we_wb;
  logic [AW-1:0] rf_a3_wb;
  logic [31:0]   rf_wd_wb;
  logic          stall;
  logic          flush;
  logic [31:0]   rd1_raw;
  logic [31:0]   rd2_raw;
  logic [1:0]    npc_op;
  logic [31:0]   npc_value;
  logic          redirect_flush;
  logic          ex_valid;
  logic [31:0]   ex_instr;
  logic [31:0]   ex_pc;
  logic [31:0]   ex_rd1;
  logic [31:0]   ex_rd2;
  logic [31:0]   ex_imm;
  logic [31:0]   ex_link;

  modport master (
    output instr_id, pc_id, valid_id, fwd_rd1, fwd_rd2, rf_we_wb, rf_a3_wb, rf_wd_wb, stall, flush,
    input  rd1_raw, rd2_raw, npc_op, npc_value, redirect_flush,
           ex_valid, ex_instr, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_link
  );

  modport slave (
    input  instr_id, pc_id, valid_id, fwd_rd1, fwd_rd2, rf_we_wb, rf_a3_wb, rf_wd_wb, stall, flush,
    output rd1_raw, rd2_raw, npc_op, npc_value, redirect_flush,
           ex_valid, ex_instr, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_link
  );
endinterface

// File: rtl/grf_bypass.sv
// NREG x 32 register file, r0 hardwired to zero, write-first bypass on both read ports.
module grf_bypass #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] a3,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2
);
  localparam int NPORT = 2;

  logic [NREG-1:0][31:0]  regs;
  logic [NPORT-1:0][AW-1:0] ra;
  logic [NPORT-1:0][31:0]   rd;

  assign ra  = {a2, a1};
  assign rd1 = rd[0];
  assign rd2 = rd[1];

  // Write port; r0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk) begin
    if (reset)                regs     <= '0;
    else if (we && a3 != '0)  regs[a3] <= wd;
  end

  // Read ports: r0 forced zero, same-cycle WB data wins over stored value
  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    assign rd[p] = (ra[p] == '0)            ? 32'h0 :
                   (we && ra[p] == a3)      ? wd    : regs[ra[p]];
  end
endmodule

// File: rtl/id_stage_param.sv
// MIPS decode stage: operand read, branch compare, next-PC/immediate/link generation, ID/EX register.
module id_stage_param
  import id_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int AW         = $clog2(NREG),
  parameter bit DELAY_SLOT = 1'b1
) (
  input logic clk,
  input logic reset,
  id_stage_param_if.slave bus
);
  localparam int STAGES = 1;

  logic [5:0]  op, fn;
  logic [4:0]  rt_f;
  logic [15:0] imm16;
  logic [31:0] rd1, rd2, pc4, br_tgt, j_tgt, link_val, imm;
  logic signed [31:0] s1, s2;
  cmp_e        cmp;
  ext_e        ext;
  logic        is_j, is_jr, is_link, taken;
  npc_op_e     npc_op;
  logic [31:0] npc_value;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_q;
  ex_data_t    ex_q;

  assign op    = bus.instr_id[31:26];
  assign fn    = bus.instr_id[5:0];
  assign rt_f  = bus.instr_id[20:16];
  assign imm16 = bus.instr_id[15:0];
  assign s1    = bus.fwd_rd1;
  assign s2    = bus.fwd_rd2;

  grf_bypass #(.NREG(NREG), .AW(AW)) u_grf (
    .clk   (clk),
    .reset (reset),
    .we    (bus.rf_we_wb),
    .a3    (bus.rf_a3_wb),
    .wd    (bus.rf_wd_wb),
    .a1    (bus.instr_id[21 +: AW]),
    .a2    (bus.instr_id[16 +: AW]),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // Opcode decode into compare mode, extension mode and jump/link flags
  always_comb begin
    cmp     = CMP_NONE;
    ext     = EXT_SIGN;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_link = 1'b0;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_JR)   is_jr = 1'b1;
        if (fn == FN_JALR) begin is_jr = 1'b1; is_link = 1'b1; end
      end
      OP_REGIMM: begin
        if (rt_f == RT_BLTZ) cmp = CMP_LTZ;
        if (rt_f == RT_BGEZ) cmp = CMP_GEZ;
      end
      OP_J:    is_j = 1'b1;
      OP_JAL:  begin is_j = 1'b1; is_link = 1'b1; end
      OP_BEQ:  cmp = CMP_EQ;
      OP_BNE:  cmp = CMP_NE;
      OP_BLEZ: cmp = CMP_LEZ;
      OP_BGTZ: cmp = CMP_GTZ;
      OP_ANDI, OP_ORI, OP_XORI: ext = EXT_ZERO;
      OP_LUI:  ext = EXT_LUI;
      default: ;
    endcase
  end

  // Signed branch compare on forwarded operands
  always_comb begin
    taken = 1'b0;
    case (cmp)
      CMP_EQ:  taken = (s1 == s2);
      CMP_NE:  taken = (s1 != s2);
      CMP_LEZ: taken = (s1 <= 0);
      CMP_GTZ: taken = (s1 >  0);
      CMP_LTZ: taken = (s1 <  0);
      CMP_GEZ: taken = (s1 >= 0);
      default: taken = 1'b0;
    endcase
  end

  assign pc4      = bus.pc_id + 32'd4;
  assign br_tgt   = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt    = {pc4[31:28], bus.instr_id[25:0], 2'b00};
  assign link_val = bus.pc_id + (DELAY_SLOT ? 32'd8 : 32'd4);
  assign imm      = ext_imm(imm16, ext);

  // Redirect select, suppressed for stalled or non-valid slots
  always_comb begin
    npc_op = NPC_PC4;
    if (bus.valid_id && !bus.stall) begin
      if (is_jr)      npc_op = NPC_JR;
      else if (is_j)  npc_op = NPC_J;
      else if (taken) npc_op = NPC_BR;
    end
    case (npc_op)
      NPC_BR:  npc_value = br_tgt;
      NPC_J:   npc_value = j_tgt;
      NPC_JR:  npc_value = bus.fwd_rd1;
      default: npc_value = pc4;
    endcase
  end

  assign bus.rd1_raw        = rd1;
  assign bus.rd2_raw        = rd2;
  assign bus.npc_op         = npc_op;
  assign bus.npc_value      = npc_value;
  assign bus.redirect_flush = !DELAY_SLOT && (npc_op != NPC_PC4);

  assign vld_pipe = {vld_q, bus.valid_id & ~bus.stall & ~bus.flush};

  // Valid shift: stall/flush already folded into the entry bit
  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_pipe[STAGES-1:0];
  end

  // ID/EX payload: reset, then bubble on stall/flush, else load
  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.stall) ex_q <= '0;
    else begin
      ex_q.instr <= bus.instr_id;
      ex_q.pc    <= bus.pc_id;
      ex_q.rd1   <= rd1;
      ex_q.rd2   <= rd2;
      ex_q.imm   <= imm;
      ex_q.link  <= is_link ? link_val : 32'h0;
    end
  end

  assign bus.ex_valid = vld_q[STAGES];
  assign bus.ex_instr = ex_q.instr;
  assign bus.ex_pc    = ex_q.pc;
  assign bus.ex_rd1   = ex_q.rd1;
  assign bus.ex_rd2   = ex_q.rd2;
  assign bus.ex_imm   = ex_q.imm;
  assign bus.ex_link  = ex_q.link;
endmodule
